tlc_chain_receiver: RTL and testbench

//  Receive end of the TLC5940-style LED chain interface: rebuilds a DEVICES-long daisy chain from

---
 rtl/tlc_chain_receiver.sv | 181 ++++++++++++++++++
 tb/tb_tlc_chain_receiver.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_chain_receiver.sv
// Receive end of a TLC5940-style LED daisy chain. Every pin is synchronised
// to the system clock and edge detected. Serial frames are rebuilt in a
// chain-length shift register and latched into grayscale or dot-correction
// storage on xlat. A per-channel grayscale PWM runs from gsclk/blank.
`timescale 1ns/1ps

module tlc_chain_receiver #(
    parameter int DEVICES = 3,
    parameter int SYNC    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      led_sclk,
    input  logic                      led_sin,
    input  logic                      led_xlat,
    input  logic                      led_mode,
    input  logic                      led_blank,
    input  logic                      led_gsclk,
    output logic [DEVICES*16-1:0]     pwm_out,
    output logic [DEVICES*16*12-1:0]  gs_latched,
    output logic [DEVICES*16*6-1:0]   dc_latched,
    output logic [11:0]               gs_count,
    output logic                      frame_done,
    output logic                      len_err
);

    localparam int CH = DEVICES * 16;
    localparam int GS = DEVICES * 192;
    localparam int DC = DEVICES * 96;

    // Bit counter is 10 bits wide and saturates, so lengths are compared in that width.
    localparam logic [9:0] GS_LEN  = 10'(GS);
    localparam logic [9:0] DC_LEN  = 10'(DC);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    localparam logic [1:0] BLANKED  = 2'd0;
    localparam logic [1:0] COUNTING = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;

    logic [SYNC-1:0] sclk_sync, sin_sync, xlat_sync, mode_sync, blank_sync, gsclk_sync;

    // Stage p0: synchronised pin levels
    logic sclk_p0, sin_p0, xlat_p0, mode_p0, blank_p0, gsclk_p0;
    // Stage p1: previous synchronised level for rise detection
    logic sclk_p1, xlat_p1, gsclk_p1;

    logic sclk_rise, xlat_rise, gsclk_rise;

    logic [GS-1:0] sr;
    logic [GS-1:0] sr_next;
    logic [9:0]    bit_cnt;
    logic [9:0]    cnt_next;
    logic [1:0]    state;

    assign sclk_p0  = sclk_sync[SYNC-1];
    assign sin_p0   = sin_sync[SYNC-1];
    assign xlat_p0  = xlat_sync[SYNC-1];
    assign mode_p0  = mode_sync[SYNC-1];
    assign blank_p0 = blank_sync[SYNC-1];
    assign gsclk_p0 = gsclk_sync[SYNC-1];

    assign sclk_rise  = sclk_p0  & ~sclk_p1;
    assign xlat_rise  = xlat_p0  & ~xlat_p1;
    assign gsclk_rise = gsclk_p0 & ~gsclk_p1;

    // Synchroniser chains; blank powers up asserted so outputs stay dark until released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync  <= '0;
            sin_sync   <= '0;
            xlat_sync  <= '0;
            mode_sync  <= '0;
            blank_sync <= '1;
            gsclk_sync <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC-2:0],  led_sclk};
            sin_sync   <= {sin_sync[SYNC-2:0],   led_sin};
            xlat_sync  <= {xlat_sync[SYNC-2:0],  led_xlat};
            mode_sync  <= {mode_sync[SYNC-2:0],  led_mode};
            blank_sync <= {blank_sync[SYNC-2:0], led_blank};
            gsclk_sync <= {gsclk_sync[SYNC-2:0], led_gsclk};
        end
    end

    // One-flop edge detectors on the strobe-like pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_p1  <= 1'b0;
            xlat_p1  <= 1'b0;
            gsclk_p1 <= 1'b0;
        end else begin
            sclk_p1  <= sclk_p0;
            xlat_p1  <= xlat_p0;
            gsclk_p1 <= gsclk_p0;
        end
    end

    // Shift result for this cycle, so a coincident xlat latches the just-shifted bit.
    always_comb begin
        sr_next  = sr;
        cnt_next = bit_cnt;
        if (sclk_rise) begin
            sr_next = {sr[GS-2:0], sin_p0};
            if (bit_cnt != CNT_MAX) begin
                cnt_next = bit_cnt + 10'd1;
            end
        end
    end

    // Shift register, bit counter and frame latches with length check.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            gs_latched <= '0;
            dc_latched <= '0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            sr         <= sr_next;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            if (xlat_rise) begin
                bit_cnt    <= '0;
                frame_done <= 1'b1;
                if (mode_p0) begin
                    dc_latched <= sr_next[DC-1:0];
                    len_err    <= (cnt_next != DC_LEN);
                end else begin
                    gs_latched <= sr_next[GS-1:0];
                    len_err    <= (cnt_next != GS_LEN);
                end
            end else begin
                bit_cnt <= cnt_next;
            end
        end
    end

    // Grayscale counter FSM: blank dominates, count stops and parks at 4095.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BLANKED;
            gs_count <= '0;
        end else if (blank_p0) begin
            state    <= BLANKED;
            gs_count <= '0;
        end else begin
            case (state)
                BLANKED: begin
                    state <= COUNTING;
                end
                COUNTING: begin
                    if (gsclk_rise) begin
                        gs_count <= gs_count + 12'd1;
                        if (gs_count == 12'hFFE) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= BLANKED;
                end
            endcase
        end
    end

    // Registered channel outputs: lit while counting and below the latched level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                pwm_out[n] <= (state == COUNTING) && (gs_count < gs_latched[12*n +: 12]);
            end
        end
    end

endmodule

// File: tb/tb_tlc_chain_receiver.sv
// Scoreboard bench for tlc_chain_receiver: frames are modelled as they are
// shifted, expected latches queued at xlat and compared at frame_done; PWM
// behaviour is checked by counting lit gsclk periods.
`timescale 1ns/1ps

module tb_tlc_chain_receiver;

    localparam int DEVICES = 3;
    localparam int CH = DEVICES * 16;
    localparam int GS = DEVICES * 192;
    localparam int DC = DEVICES * 96;

    logic               clock;
    logic               reset_n;
    logic               led_sclk, led_sin, led_xlat, led_mode, led_blank, led_gsclk;
    logic [CH-1:0]      pwm_out;
    logic [CH*12-1:0]   gs_latched;
    logic [CH*6-1:0]    dc_latched;
    logic [11:0]        gs_count;
    logic               frame_done;
    logic               len_err;

    typedef struct {
        logic          mode;
        logic [GS-1:0] data;
        logic          len_err;
    } exp_t;

    exp_t          sb[$];
    logic [GS-1:0] model_sr;
    int            model_cnt;
    int            errors;
    int            checks;

    tlc_chain_receiver #(.DEVICES(DEVICES), .SYNC(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .led_sclk   (led_sclk),
        .led_sin    (led_sin),
        .led_xlat   (led_xlat),
        .led_mode   (led_mode),
        .led_blank  (led_blank),
        .led_gsclk  (led_gsclk),
        .pwm_out    (pwm_out),
        .gs_latched (gs_latched),
        .dc_latched (dc_latched),
        .gs_count   (gs_count),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.mode    = led_mode;
        e.data    = model_sr;
        e.len_err = (model_cnt != (led_mode ? DC : GS));
        sb.push_back(e);
        model_cnt = 0;
    endtask

    task automatic wait_frame();
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_done_timeout got=0 want=1");
            if (sb.size() > 0) e = sb.pop_front();
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=frame_done want=no_frame");
        end else begin
            e = sb.pop_front();
            checks++;
            if (e.mode) begin
                if (dc_latched !== e.data[DC-1:0]) begin
                    errors++;
                    $display("FAIL dc_latched got=%h want=%h", dc_latched, e.data[DC-1:0]);
                end
            end else begin
                if (gs_latched !== e.data) begin
                    errors++;
                    $display("FAIL gs_latched got=%h want=%h", gs_latched, e.data);
                end
            end
            checks++;
            if (len_err !== e.len_err) begin
                errors++;
                $display("FAIL len_err got=%0b want=%0b", len_err, e.len_err);
            end
            tick(1);
            checks++;
            if (frame_done !== 1'b0 || len_err !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width got=%0b%0b want=00", frame_done, len_err);
            end
        end
    endtask

    // One serial bit; optionally raise xlat together with this sclk rise.
    task automatic send_bit(input logic b, input logic with_xlat);
        led_sin  = b;
        led_sclk = 1'b0;
        tick(3);
        led_sclk = 1'b1;
        model_sr = {model_sr[GS-2:0], b};
        if (model_cnt < 1023) model_cnt++;
        if (with_xlat) begin
            led_xlat = 1'b1;
            push_expect();
            tick(3);
            wait_frame();
            led_xlat = 1'b0;
        end else begin
            tick(3);
        end
        led_sclk = 1'b0;
    endtask

    task automatic send_vec(input logic [GS-1:0] v, input int n, input logic last_xlat);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i], last_xlat && (i == 0));
        end
    endtask

    task automatic do_xlat();
        tick(3);
        push_expect();
        led_xlat = 1'b1;
        wait_frame();
        tick(2);
        led_xlat = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        led_sclk = 0; led_sin = 0; led_xlat = 0; led_mode = 0; led_blank = 1; led_gsclk = 0;
        model_sr = '0; model_cnt = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        tick(3);
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL rst_pwm got=%h want=0", pwm_out); end
        checks++; if (gs_count !== 12'd0) begin errors++; $display("FAIL rst_gs_count got=%0d want=0", gs_count); end
        checks++; if (gs_latched !== '0) begin errors++; $display("FAIL rst_gs_latched got=%h want=0", gs_latched); end
        checks++; if (dc_latched !== '0) begin errors++; $display("FAIL rst_dc_latched got=%h want=0", dc_latched); end
        checks++; if (frame_done !== 1'b0 || len_err !== 1'b0) begin
            errors++; $display("FAIL rst_pulses got=%0b%0b want=00", frame_done, len_err);
        end
        reset_n = 1'b1;
        tick(8);
        checks++; if (pwm_out !== '0 || gs_count !== 12'd0) begin
            errors++; $display("FAIL blank_hold got=%h/%0d want=0/0", pwm_out, gs_count);
        end
        checks++; if (frame_done !== 1'b0 || len_err !== 1'b0) begin
            errors++; $display("FAIL idle_pulses got=%0b%0b want=00", frame_done, len_err);
        end
    endtask

    task automatic test_dc_frame();
        logic [GS-1:0] v;
        int bad;
        v = '0;
        for (int c = 0; c < CH; c++) v[6*c +: 6] = 6'h02;
        led_mode = 1'b1;
        tick(3);
        send_vec(v, DC, 1'b0);
        do_xlat();
        bad = 0;
        for (int c = 0; c < CH; c++) if (dc_latched[6*c +: 6] !== 6'h02) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL dc_channels got=%0d_bad want=0_bad", bad); end
    endtask

    task automatic test_gs_pwm();
        logic [GS-1:0] v;
        int hi0, hi1;
        bit others;
        v = '0;
        v[11:0]  = 12'h0FF;
        v[23:12] = 12'h0FF;
        led_mode = 1'b0;
        tick(3);
        send_vec(v, GS, 1'b0);
        do_xlat();
        hi0 = 0; hi1 = 0; others = 1'b0;
        led_blank = 1'b0;
        tick(6);
        for (int p = 0; p < 300; p++) begin
            if (pwm_out[0] === 1'b1) hi0++;
            if (pwm_out[1] === 1'b1) hi1++;
            for (int j = 0; j < 6; j++) begin
                led_gsclk = (j < 3);
                tick(1);
                if (|pwm_out[CH-1:2]) others = 1'b1;
            end
        end
        checks++; if (hi0 != 255) begin errors++; $display("FAIL pwm0_periods got=%0d want=255", hi0); end
        checks++; if (hi1 != 255) begin errors++; $display("FAIL pwm1_periods got=%0d want=255", hi1); end
        checks++; if (others) begin errors++; $display("FAIL pwm_others got=1 want=0"); end
        checks++; if (gs_count !== 12'd300) begin errors++; $display("FAIL gs_count_300 got=%0d want=300", gs_count); end
        led_blank = 1'b1;
        tick(6);
        checks++; if (gs_count !== 12'd0 || pwm_out !== '0) begin
            errors++; $display("FAIL blank_clear got=%0d/%h want=0/0", gs_count, pwm_out);
        end
    endtask

    task automatic test_short_frame();
        logic [GS-1:0] v;
        for (int k = 0; k < GS / 32; k++) v[32*k +: 32] = $urandom;
        led_mode = 1'b0;
        tick(3);
        send_vec(v, GS - 1, 1'b0);
        do_xlat();
    endtask

    task automatic test_back_to_back();
        logic [GS-1:0] v;
        for (int k = 0; k < GS / 32; k++) v[32*k +: 32] = $urandom;
        v[0] = 1'b1;
        led_mode = 1'b0;
        tick(3);
        send_vec(v, GS, 1'b1);
        tick(3);
    endtask

    task automatic test_full_scale();
        logic [GS-1:0] v;
        int hi0, hi2, hi3;
        v = '0;
        v[11:0]  = 12'hFFF;
        v[35:24] = 12'h001;
        led_mode = 1'b0;
        tick(3);
        send_vec(v, GS, 1'b0);
        do_xlat();
        hi0 = 0; hi2 = 0; hi3 = 0;
        led_blank = 1'b0;
        tick(6);
        for (int p = 0; p < 4100; p++) begin
            if (pwm_out[0] === 1'b1) hi0++;
            if (pwm_out[2] === 1'b1) hi2++;
            if (pwm_out[3] === 1'b1) hi3++;
            led_gsclk = 1'b1;
            tick(3);
            led_gsclk = 1'b0;
            tick(3);
        end
        checks++; if (gs_count !== 12'hFFF) begin errors++; $display("FAIL gs_count_sat got=%0d want=4095", gs_count); end
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL done_dark got=%h want=0", pwm_out); end
        checks++; if (hi0 != 4095) begin errors++; $display("FAIL pwm_fullscale got=%0d want=4095", hi0); end
        checks++; if (hi2 != 1) begin errors++; $display("FAIL pwm_one got=%0d want=1", hi2); end
        checks++; if (hi3 != 0) begin errors++; $display("FAIL pwm_zero got=%0d want=0", hi3); end
        led_blank = 1'b1;
        tick(6);
        checks++; if (gs_count !== 12'd0) begin errors++; $display("FAIL restart_clear got=%0d want=0", gs_count); end
        led_blank = 1'b0;
        tick(6);
        led_gsclk = 1'b1;
        tick(3);
        led_gsclk = 1'b0;
        tick(3);
        checks++; if (gs_count !== 12'd1 || pwm_out[0] !== 1'b1) begin
            errors++; $display("FAIL restart_count got=%0d/%0b want=1/1", gs_count, pwm_out[0]);
        end
        led_blank = 1'b1;
        tick(6);
    endtask

    task automatic test_reset_midframe();
        logic [GS-1:0] v;
        for (int k = 0; k < GS / 32; k++) v[32*k +: 32] = $urandom;
        led_mode = 1'b0;
        tick(3);
        send_vec(v, 200, 1'b0);
        reset_n = 1'b0;
        model_sr = '0;
        model_cnt = 0;
        #2;
        checks++; if (gs_latched !== '0 || dc_latched !== '0) begin
            errors++; $display("FAIL midframe_reset got=nonzero_latch want=0");
        end
        tick(2);
        reset_n = 1'b1;
        tick(4);
        for (int k = 0; k < GS / 32; k++) v[32*k +: 32] = $urandom;
        send_vec(v, GS, 1'b0);
        do_xlat();
        checks++; if (gs_latched !== v) begin
            errors++; $display("FAIL post_reset_frame got=%h want=%h", gs_latched, v);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_dc_frame();
        test_gs_pwm();
        test_short_frame();
        test_back_to_back();
        test_full_scale();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
